// File: rtl/stopwatch_time_counter.sv
// Stopwatch timebase: divides clk to a 1 s tick and keeps a minutes:seconds count.
// Optional BCD digit outputs are enabled with the STOPWATCH_BCD_OUT_EN macro (requires MAX_MIN <= 99).
module stopwatch_time_counter #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned MAX_MIN  = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       count_en,
  input  logic       clear_timers,
  output logic [5:0] seconds,
  output logic [6:0] minutes,
  output logic       sec_tick,
  output logic       wrap
`ifdef STOPWATCH_BCD_OUT_EN
  ,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens
`endif
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = 6;
  localparam int unsigned MW = 7;

  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_seconds;
  logic [MW-1:0] r_minutes;
  logic          r_sec_tick;
  logic          r_wrap;

  logic [PW-1:0] w_presc_nxt;
  logic [SW-1:0] w_seconds_nxt;
  logic [MW-1:0] w_minutes_nxt;
  logic          w_sec_tick_nxt;
  logic          w_wrap_nxt;
  logic          w_presc_last;
  logic          w_sec_last;
  logic          w_min_last;

`ifdef STOPWATCH_BCD_OUT_EN
  logic [3:0] r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
  logic [3:0] w_sec_ones_nxt, w_sec_tens_nxt, w_min_ones_nxt, w_min_tens_nxt;
`endif

  assign w_presc_last = (r_presc == PW'(TICK_DIV - 1));
  assign w_sec_last   = (r_seconds == SW'(59));
  assign w_min_last   = (r_minutes == MW'(MAX_MIN));

  // Next-state for prescaler and binary time; clear wins over count_en and drops any pending tick.
  always_comb begin
    w_presc_nxt    = r_presc;
    w_seconds_nxt  = r_seconds;
    w_minutes_nxt  = r_minutes;
    w_sec_tick_nxt = 1'b0;
    w_wrap_nxt     = 1'b0;
    if (clear_timers) begin
      w_presc_nxt   = '0;
      w_seconds_nxt = '0;
      w_minutes_nxt = '0;
    end else if (count_en) begin
      if (w_presc_last) begin
        w_presc_nxt    = '0;
        w_sec_tick_nxt = 1'b1;
        if (w_sec_last) begin
          w_seconds_nxt = '0;
          if (w_min_last) begin
            w_minutes_nxt = '0;
            w_wrap_nxt    = 1'b1;
          end else begin
            w_minutes_nxt = r_minutes + MW'(1);
          end
        end else begin
          w_seconds_nxt = r_seconds + SW'(1);
        end
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end
  end

`ifdef STOPWATCH_BCD_OUT_EN
  // BCD digit counters stepped on exactly the same tick/carry conditions as the binary count.
  always_comb begin
    w_sec_ones_nxt = r_sec_ones;
    w_sec_tens_nxt = r_sec_tens;
    w_min_ones_nxt = r_min_ones;
    w_min_tens_nxt = r_min_tens;
    if (clear_timers) begin
      w_sec_ones_nxt = '0;
      w_sec_tens_nxt = '0;
      w_min_ones_nxt = '0;
      w_min_tens_nxt = '0;
    end else if (count_en && w_presc_last) begin
      if (w_sec_last) begin
        w_sec_ones_nxt = '0;
        w_sec_tens_nxt = '0;
        if (w_min_last) begin
          w_min_ones_nxt = '0;
          w_min_tens_nxt = '0;
        end else if (r_min_ones == 4'd9) begin
          w_min_ones_nxt = '0;
          w_min_tens_nxt = r_min_tens + 4'd1;
        end else begin
          w_min_ones_nxt = r_min_ones + 4'd1;
        end
      end else if (r_sec_ones == 4'd9) begin
        w_sec_ones_nxt = '0;
        w_sec_tens_nxt = r_sec_tens + 4'd1;
      end else begin
        w_sec_ones_nxt = r_sec_ones + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sec_ones <= '0;
      r_sec_tens <= '0;
      r_min_ones <= '0;
      r_min_tens <= '0;
    end else begin
      r_sec_ones <= w_sec_ones_nxt;
      r_sec_tens <= w_sec_tens_nxt;
      r_min_ones <= w_min_ones_nxt;
      r_min_tens <= w_min_tens_nxt;
    end
  end

  assign sec_ones = r_sec_ones;
  assign sec_tens = r_sec_tens;
  assign min_ones = r_min_ones;
  assign min_tens = r_min_tens;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc    <= '0;
      r_seconds  <= '0;
      r_minutes  <= '0;
      r_sec_tick <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_presc    <= w_presc_nxt;
      r_seconds  <= w_seconds_nxt;
      r_minutes  <= w_minutes_nxt;
      r_sec_tick <= w_sec_tick_nxt;
      r_wrap     <= w_wrap_nxt;
    end
  end

  assign seconds  = r_seconds;
  assign minutes  = r_minutes;
  assign sec_tick = r_sec_tick;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Scoreboard bench: two stopwatch instances (TICK_DIV=4/MAX_MIN=99 and TICK_DIV=1/MAX_MIN=2)
// driven by the same stimulus and checked against an elapsed-edge-count reference model.
module tb_stopwatch_time_counter;

  localparam int unsigned TD_A = 4;
  localparam int unsigned MM_A = 99;
  localparam int unsigned TD_B = 1;
  localparam int unsigned MM_B = 2;

  typedef struct {
    int sec;
    int min;
    int tick;
    int wrap;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic count_en = 1'b0;
  logic clear_timers = 1'b0;

  logic [5:0] sec_a, sec_b;
  logic [6:0] min_a, min_b;
  logic       tick_a, tick_b, wrap_a, wrap_b;

`ifdef STOPWATCH_BCD_OUT_EN
  logic [3:0] so_a, st_a, mo_a, mt_a, so_b, st_b, mo_b, mt_b;
`endif

  pair_t       sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned e_a = 0;
  int unsigned e_b = 0;

  always #5 clk = ~clk;

  stopwatch_time_counter #(.TICK_DIV(TD_A), .MAX_MIN(MM_A)) u_dut_a (
    .clk(clk), .rst(rst), .count_en(count_en), .clear_timers(clear_timers),
    .seconds(sec_a), .minutes(min_a), .sec_tick(tick_a), .wrap(wrap_a)
`ifdef STOPWATCH_BCD_OUT_EN
    , .sec_ones(so_a), .sec_tens(st_a), .min_ones(mo_a), .min_tens(mt_a)
`endif
  );

  stopwatch_time_counter #(.TICK_DIV(TD_B), .MAX_MIN(MM_B)) u_dut_b (
    .clk(clk), .rst(rst), .count_en(count_en), .clear_timers(clear_timers),
    .seconds(sec_b), .minutes(min_b), .sec_tick(tick_b), .wrap(wrap_b)
`ifdef STOPWATCH_BCD_OUT_EN
    , .sec_ones(so_b), .sec_tens(st_b), .min_ones(mo_b), .min_tens(mt_b)
`endif
  );

  // Reference: time is simply (enabled edges since last clear) / td, modulo one full wrap period.
  task automatic model_step(input int unsigned td, input int unsigned mm,
                            input logic r, input logic en, input logic clr,
                            input int unsigned e_in, output int unsigned e_out, output exp_t x);
    int unsigned period;
    int unsigned ticks;
    period = 60 * (mm + 1);
    e_out  = e_in;
    x.tick = 0;
    x.wrap = 0;
    if (r || clr) begin
      e_out = 0;
    end else if (en) begin
      e_out = e_in + 1;
      if (e_out % td == 0) begin
        x.tick = 1;
        if ((e_out / td) % period == 0) x.wrap = 1;
      end
      if (e_out == td * period) e_out = 0;
    end
    ticks = e_out / td;
    x.sec = int'(ticks % 60);
    x.min = int'(ticks / 60);
  endtask

  task automatic step(input logic r, input logic en, input logic clr);
    pair_t p;
    int unsigned na, nb;
    @(negedge clk);
    rst          = r;
    count_en     = en;
    clear_timers = clr;
    model_step(TD_A, MM_A, r, en, clr, e_a, na, p.a);
    model_step(TD_B, MM_B, r, en, clr, e_b, nb, p.b);
    e_a = na;
    e_b = nb;
    sb_q.push_back(p);
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) step(1'b0, en, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation after each edge that follows stimulus.
  initial begin
    pair_t p;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        p = sb_q.pop_front();
        chk("a_seconds",  int'(sec_a),  p.a.sec);
        chk("a_minutes",  int'(min_a),  p.a.min);
        chk("a_sec_tick", int'(tick_a), p.a.tick);
        chk("a_wrap",     int'(wrap_a), p.a.wrap);
        chk("b_seconds",  int'(sec_b),  p.b.sec);
        chk("b_minutes",  int'(min_b),  p.b.min);
        chk("b_sec_tick", int'(tick_b), p.b.tick);
        chk("b_wrap",     int'(wrap_b), p.b.wrap);
`ifdef STOPWATCH_BCD_OUT_EN
        chk("a_sec_ones", int'(so_a), p.a.sec % 10);
        chk("a_sec_tens", int'(st_a), p.a.sec / 10);
        chk("a_min_ones", int'(mo_a), p.a.min % 10);
        chk("a_min_tens", int'(mt_a), p.a.min / 10);
        chk("b_sec_ones", int'(so_b), p.b.sec % 10);
        chk("b_sec_tens", int'(st_b), p.b.sec / 10);
        chk("b_min_ones", int'(mo_b), p.b.min % 10);
        chk("b_min_tens", int'(mt_b), p.b.min / 10);
`endif
      end
    end
  end

  initial begin
    int drain;
    // reset held for two edges
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    // basic ticking
    run(8, 1'b1);
    // pause preserves fraction
    step(1'b0, 1'b0, 1'b1);
    run(2, 1'b1);
    run(10, 1'b0);
    run(2, 1'b1);
    // minute carry and full wrap on the TICK_DIV=1 instance
    step(1'b0, 1'b1, 1'b1);
    run(60, 1'b1);
    run(120, 1'b1);
    run(5, 1'b1);
    // clear priority at prescaler=3, seconds=5 on the TICK_DIV=4 instance
    step(1'b0, 1'b0, 1'b1);
    run(23, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    run(5, 1'b1);
    // reset mid-count
    run(7, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    run(6, 1'b1);
    // full wrap of the MAX_MIN=99 instance
    step(1'b0, 1'b0, 1'b1);
    run(TD_A * 60 * (MM_A + 1) + 3, 1'b1);
    // random mix
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
    end
    drain = 0;
    while (sb_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
Timebase and time-of-count datapath downstream of the stopwatch control FSM. Consumes the FSM's count_en and clear_timers levels, divides clk down to a 1 s tick, and maintains a minutes:seconds count for the display stage. All outputs are registered.

Parameters:
TICK_DIV, 50_000_000, clk cycles per 1 s tick (legal range >= 1)
MAX_MIN, 99, highest minutes value before wrap to 00:00 (legal range 1..127)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
count_en  input  1  level from FSM; advance timebase while high
clear_timers  input  1  level from FSM; zero all time state
seconds  output  6  seconds count, 0..59
minutes  output  7  minutes count, 0..MAX_MIN
sec_tick  output  1  one-cycle pulse on every seconds increment
wrap  output  1  one-cycle pulse when count wraps MAX_MIN:59 -> 00:00

Behaviour:
- One clock, clk. Reset is synchronous and active-high, on rst.
- Reset (rst=1 at an edge): prescaler=0, seconds=0, minutes=0, sec_tick=0, wrap=0. rst beats all other inputs.
- Internal prescaler: ceil(log2(TICK_DIV)) bits, minimum 1 bit.
- Priority per edge: rst > clear_timers > count_en > hold.
- clear_timers=1: prescaler, seconds, minutes <= 0 and sec_tick, wrap <= 0, regardless of count_en. A tick that would have fired on this edge is discarded.
- count_en=1, clear_timers=0:
  - prescaler < TICK_DIV-1: prescaler += 1, no tick.
  - prescaler == TICK_DIV-1: prescaler <= 0 and sec_tick <= 1 for exactly the following cycle. seconds increments on the same edge.
- Seconds carry:
  - seconds == 59 on a tick: seconds <= 0 and minutes += 1.
  - minutes == MAX_MIN and seconds == 59 on a tick: seconds <= 0, minutes <= 0, wrap <= 1 for one cycle. sec_tick also pulses on that cycle.
- count_en=0, clear_timers=0 (pause): prescaler, seconds, minutes hold. The fractional second is preserved across pause and resume. sec_tick and wrap are 0.
- TICK_DIV=1: a tick occurs on every enabled edge. sec_tick stays high continuously while count_en=1.
- Latency: seconds/minutes change on the same edge that sets sec_tick. Outputs become valid the cycle after that edge.
- rst or clear_timers asserted mid-count: zero state on that edge. Counting resumes from 00:00.0 on the next enabled edge.
- No combinational path from inputs to outputs.

Optional Feature:
Macro: STOPWATCH_BCD_OUT_EN.
- Defined: adds four 4-bit output ports after wrap: sec_ones, sec_tens, min_ones, min_tens.
  - They hold the BCD digits of seconds and minutes and are kept as registered BCD counters updated on the same edges as the binary counts.
  - Reset/clear value is 0.
  - min_tens covers 0..(MAX_MIN/10) and must not exceed 9, so MAX_MIN <= 99 when the macro is defined.
- Undefined: these ports and their registers are absent. Binary behaviour is identical in both builds.

Test Plan:
- Reset with TICK_DIV=4: hold rst=1 for 2 edges, release -> seconds=0, minutes=0, sec_tick=0, wrap=0.
- Basic tick, TICK_DIV=4: count_en=1 for 4 edges -> after edge 4, seconds=1 and sec_tick=1 for exactly one cycle. After 8 edges, seconds=2.
- Pause preserves fraction, TICK_DIV=4: count_en=1 for 2 edges, 0 for 10 edges, 1 for 2 edges -> seconds goes 0->1 only on the 4th enabled edge, with no tick during the pause.
- Minute carry, TICK_DIV=1: 60 enabled edges from 00:00 -> minutes=1, seconds=0, wrap=0.
- Full wrap, TICK_DIV=1, MAX_MIN=2: 180 enabled edges -> 00:00 with wrap=1 and sec_tick=1 for one cycle. With STOPWATCH_BCD_OUT_EN, all four digits read 0.
- Clear priority, TICK_DIV=4: at prescaler=3 with seconds=5, drive count_en=1 and clear_timers=1 together -> next cycle seconds=0, minutes=0, sec_tick=0. First tick then follows 4 enabled edges later.
